// File: rtl/ddr3_port_arbiter_pkg.sv
// ddr3_pkg: command codes, FSM encodings and burst sizing shared by the DDR3 port arbiter
package ddr3_pkg;
    localparam logic [2:0] CMD_NOP = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;
    localparam logic [2:0] CMD_WR = 3'b010;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WDATA = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    function automatic logic [5:0] words_per_cmd(input logic [1:0] sz, input int bl);
        return 6'((int'(sz) + 1) * bl);
    endfunction
endpackage

// File: rtl/ddr3_port_arbiter_if.sv
// ddr3_port_arbiter_if: host-port and controller-side signals of the DDR3 port arbiter
interface ddr3_port_arbiter_if #(
    parameter int NPORTS = 4,
    parameter int AW = 26,
    parameter int DW = 16
);
    logic [NPORTS-1:0] p_cmd_valid, p_cmd_ready, p_wvalid, p_wready, p_rvalid;
    logic [3*NPORTS-1:0] p_cmd, p_op;
    logic [2*NPORTS-1:0] p_sz;
    logic [AW*NPORTS-1:0] p_addr;
    logic [DW*NPORTS-1:0] p_wdata;
    logic [DW-1:0] p_rdata, c_din, c_dout;
    logic [AW-1:0] p_raddr, c_addr, c_raddr;
    logic c_ready, c_cmd_notfull, c_notfull, c_cmd_put, c_din_put, c_validout, err_orphan;
    logic [2:0] c_cmd, c_op;
    logic [1:0] c_sz;
    modport slave (
        input p_cmd_valid, p_cmd, p_sz, p_op, p_addr, p_wdata, p_wvalid,
        input c_ready, c_cmd_notfull, c_notfull, c_validout, c_dout, c_raddr,
        output p_cmd_ready, p_wready, p_rdata, p_raddr, p_rvalid,
        output c_cmd_put, c_cmd, c_sz, c_op, c_addr, c_din_put, c_din, err_orphan
    );
    modport master (
        output p_cmd_valid, p_cmd, p_sz, p_op, p_addr, p_wdata, p_wvalid,
        output c_ready, c_cmd_notfull, c_notfull, c_validout, c_dout, c_raddr,
        input p_cmd_ready, p_wready, p_rdata, p_raddr, p_rvalid,
        input c_cmd_put, c_cmd, c_sz, c_op, c_addr, c_din_put, c_din, err_orphan
    );
endinterface

// File: rtl/ddr3_port_arbiter_tag_fifo.sv
// ddr3_tag_fifo: in-order queue of {port, sz} tags for reads still awaiting return data
module ddr3_tag_fifo #(
    parameter int W = 4,
    parameter int DEPTH = 16
) (
    input logic clk,
    input logic resetbar,
    input logic push,
    input logic [W-1:0] din,
    input logic pop,
    output logic [W-1:0] dout,
    output logic empty,
    output logic full
);
    localparam int PTR = $clog2(DEPTH);
    typedef logic [PTR:0] cnt_t;
    logic [W-1:0] mem [DEPTH];
    logic [PTR-1:0] wp, rp;
    cnt_t cnt;
    assign dout = mem[rp];
    assign empty = cnt == '0;
    assign full = cnt == cnt_t'(DEPTH);
    always_ff @(posedge clk or negedge resetbar) begin
        if (!resetbar) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + cnt_t'(push) - cnt_t'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end
endmodule

// File: rtl/ddr3_port_arbiter.sv
// ddr3_port_arbiter: round-robin N-port front end for the ddr3_controller host interface,
// pushing write data ahead of each write command and routing read returns by tag.
module ddr3_port_arbiter
    import ddr3_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int AW = 26,
    parameter int DW = 16,
    parameter int BL = 8,
    parameter int TAG_DEPTH = 16
) (
    input logic clk,
    input logic resetbar,
    ddr3_port_arbiter_if.slave bus
);
    localparam int PW = $clog2(NPORTS);
    localparam int TW = PW + 2;
    logic [1:0] state;
    logic [PW-1:0] last_grant, g, pick;
    logic found, issue, wfire, hit, last_r, t_empty, t_full;
    logic [NPORTS-1:0] elig, g_oh;
    logic [5:0] wcnt, rcnt;
    logic [TW-1:0] head;
    // a read is only eligible while the tag queue can accept its tag
    always_comb begin
        elig = '0;
        for (int i = 0; i < NPORTS; i++)
            elig[i] = bus.p_cmd_valid[i] && !(bus.p_cmd[3*i +: 3] == CMD_RD && t_full);
    end
    always_comb begin
        found = 1'b0;
        pick = '0;
        for (int k = 1; k <= NPORTS; k++) begin
            if (!found && elig[(int'(last_grant) + k) % NPORTS]) begin
                found = 1'b1;
                pick = PW'((int'(last_grant) + k) % NPORTS);
            end
        end
    end
    assign g_oh = NPORTS'(1) << g;
    assign issue = state == ST_ISSUE && bus.c_cmd_notfull;
    assign wfire = state == ST_WDATA && bus.p_wvalid[g] && bus.c_notfull;
    assign hit = bus.c_validout && !t_empty;
    assign last_r = rcnt == words_per_cmd(head[1:0], BL) - 6'd1;
    assign bus.c_cmd_put = issue;
    assign bus.p_cmd_ready = issue ? g_oh : '0;
    assign bus.c_din_put = wfire;
    assign bus.c_din = wfire ? bus.p_wdata[DW*g +: DW] : '0;
    assign bus.p_wready = wfire ? g_oh : '0;
    assign bus.p_rvalid = hit ? NPORTS'(1) << head[TW-1:2] : '0;
    assign bus.p_rdata = hit ? bus.c_dout : '0;
    assign bus.p_raddr = hit ? bus.c_raddr : '0;
    always_ff @(posedge clk or negedge resetbar) begin
        if (!resetbar) begin
            state <= ST_IDLE;
            last_grant <= PW'(NPORTS - 1);
            g <= '0;
            wcnt <= '0;
            bus.c_cmd <= '0;
            bus.c_sz <= '0;
            bus.c_op <= '0;
            bus.c_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.c_ready && found) begin
                    g <= pick;
                    wcnt <= '0;
                    bus.c_cmd <= bus.p_cmd[3*pick +: 3];
                    bus.c_sz <= bus.p_sz[2*pick +: 2];
                    bus.c_op <= bus.p_op[3*pick +: 3];
                    bus.c_addr <= bus.p_addr[AW*pick +: AW];
                    state <= bus.p_cmd[3*pick +: 3] == CMD_WR ? ST_WDATA : ST_ISSUE;
                end
                ST_WDATA: if (wfire) begin
                    wcnt <= wcnt + 6'd1;
                    if (wcnt == words_per_cmd(bus.c_sz, BL) - 6'd1) state <= ST_ISSUE;
                end
                ST_ISSUE: if (issue) begin
                    last_grant <= g;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge resetbar) begin
        if (!resetbar) begin
            rcnt <= '0;
            bus.err_orphan <= 1'b0;
        end else begin
            if (hit) rcnt <= last_r ? 6'd0 : rcnt + 6'd1;
            if (bus.c_validout && t_empty) bus.err_orphan <= 1'b1;
        end
    end
    ddr3_tag_fifo #(.W(TW), .DEPTH(TAG_DEPTH)) u_tags (
        .clk(clk),
        .resetbar(resetbar),
        .push(issue && bus.c_cmd == CMD_RD),
        .din({g, bus.c_sz}),
        .pop(hit && last_r),
        .dout(head),
        .empty(t_empty),
        .full(t_full)
    );
endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// tb_ddr3_port_arbiter: directed sequence with randomized payloads, checked against a
// queue-based model of grants, write data ordering and in-order read return routing.
module tb_ddr3_port_arbiter;
    import ddr3_pkg::*;
    localparam int NP = 4, AW = 26, DW = 16;
    typedef struct packed {logic [2:0] cmd; logic [1:0] sz; logic [2:0] op; logic [AW-1:0] addr;} hcmd_t;
    typedef struct packed {logic [3:0] port; logic [7:0] ndin; hcmd_t c;} ient_t;
    typedef struct packed {logic [3:0] port; logic [DW-1:0] d; logic [AW-1:0] a;} went_t;
    typedef struct {logic [3:0] port; int left;} mtag_t;
    logic clk = 0, resetbar = 0;
    ddr3_port_arbiter_if #(.NPORTS(NP), .AW(AW), .DW(DW)) bus();
    ddr3_port_arbiter #(.NPORTS(NP), .AW(AW), .DW(DW), .BL(8), .TAG_DEPTH(16)) dut (
        .clk(clk), .resetbar(resetbar), .bus(bus)
    );
    always #5 clk = ~clk;
    hcmd_t hq [NP][$];
    logic [DW-1:0] wq [NP][$];
    ient_t ilog[$];
    went_t dlog[$], rlog[$], erlog[$];
    mtag_t mq[$];
    logic [NP-1:0] rdy_f = '0, wr_f = '0;
    int tests = 0, fails = 0, stall_put = 0, mlast = NP - 1;
    bit gap = 0;
    function automatic logic [3:0] idx(input logic [NP-1:0] v);
        if ($onehot(v)) for (int i = 0; i < NP; i++) if (v[i]) return 4'(i);
        return 4'hf;
    endfunction
    always @(negedge clk) begin
        rdy_f = bus.p_cmd_ready;
        wr_f = bus.p_wready;
        if (bus.c_cmd_put) ilog.push_back({idx(bus.p_cmd_ready), 8'(dlog.size()), bus.c_cmd, bus.c_sz, bus.c_op, bus.c_addr});
        if (bus.c_din_put) begin
            dlog.push_back({idx(bus.p_wready), bus.c_din, AW'(0)});
            if (!bus.c_notfull) stall_put++;
        end
        if (|bus.p_rvalid) rlog.push_back({idx(bus.p_rvalid), bus.p_rdata, bus.p_raddr});
    end
    // host model: each port holds its head command until accepted and streams its write words
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NP; i++) begin
            if (rdy_f[i] && hq[i].size() != 0) void'(hq[i].pop_front());
            if (wr_f[i] && wq[i].size() != 0) void'(wq[i].pop_front());
            bus.p_cmd_valid[i] = hq[i].size() != 0;
            if (hq[i].size() != 0) {bus.p_cmd[3*i +: 3], bus.p_sz[2*i +: 2], bus.p_op[3*i +: 3], bus.p_addr[AW*i +: AW]} = hq[i][0];
            else {bus.p_cmd[3*i +: 3], bus.p_sz[2*i +: 2], bus.p_op[3*i +: 3], bus.p_addr[AW*i +: AW]} = '0;
            bus.p_wvalid[i] = wq[i].size() != 0 && (!gap || $urandom_range(0, 2) != 0);
            bus.p_wdata[DW*i +: DW] = wq[i].size() != 0 ? wq[i][0] : '0;
        end
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic wait_cmds(input string tag, input int n, input int budget);
        for (int k = 0; k < budget && ilog.size() < n; k++) tick(1);
        chk(tag, 64'(ilog.size()), 64'(n));
    endtask
    task automatic clr();
        ilog.delete();
        dlog.delete();
        rlog.delete();
        erlog.delete();
    endtask
    function automatic hcmd_t rnd_cmd(input logic [2:0] c, input logic [1:0] sz);
        return {c, sz, 3'($urandom), AW'($urandom)};
    endfunction
    function automatic logic [2:0] other_cmd();
        logic [2:0] c = 3'($urandom);
        return (c == CMD_RD || c == CMD_WR) ? CMD_NOP : c;
    endfunction
    task automatic expect_read(input int port, input logic [1:0] sz);
        mtag_t t;
        t.port = 4'(port);
        t.left = (int'(sz) + 1) * 8;
        mq.push_back(t);
    endtask
    // controller returns n words with random idle gaps; model routes each to the oldest read
    task automatic ret(input int n);
        mtag_t t;
        for (int k = 0; k < n; ) begin
            if ($urandom_range(0, 3) == 0) bus.c_validout = 0;
            else begin
                bus.c_validout = 1;
                bus.c_dout = DW'($urandom);
                bus.c_raddr = AW'($urandom);
                if (mq.size() != 0) begin
                    t = mq.pop_front();
                    erlog.push_back({t.port, bus.c_dout, bus.c_raddr});
                    t.left--;
                    if (t.left > 0) mq.push_front(t);
                end
                k++;
            end
            tick(1);
        end
        bus.c_validout = 0;
        tick(2);
    endtask
    task automatic cmp_ret(input string tag);
        chk({tag, "_n"}, 64'(rlog.size()), 64'(erlog.size()));
        for (int k = 0; k < erlog.size() && k < rlog.size(); k++) chk(tag, rlog[k], erlog[k]);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end
    initial begin
        hcmd_t c0, c2, w, r1, r3, pr0, pw1;
        hcmd_t pl [NP][2];
        logic [DW-1:0] ew[$];
        bus.p_cmd_valid = '0; bus.p_cmd = '0; bus.p_sz = '0; bus.p_op = '0; bus.p_addr = '0;
        bus.p_wdata = '0; bus.p_wvalid = '0;
        bus.c_ready = 1; bus.c_cmd_notfull = 1; bus.c_notfull = 1;
        bus.c_validout = 0; bus.c_dout = '0; bus.c_raddr = '0;
        tick(3);
        chk("rst_cmd_put", bus.c_cmd_put, 0);
        chk("rst_cmd_ready", bus.p_cmd_ready, 0);
        chk("rst_din_put", bus.c_din_put, 0);
        chk("rst_wready", bus.p_wready, 0);
        chk("rst_rvalid", bus.p_rvalid, 0);
        chk("rst_err", bus.err_orphan, 0);
        chk("rst_c_cmd", {bus.c_cmd, bus.c_sz, bus.c_op, bus.c_addr}, 0);
        resetbar = 1;
        tick(2);
        // two reads on ports 0 and 2, then their returns
        clr();
        c0 = rnd_cmd(CMD_RD, 0); c2 = rnd_cmd(CMD_RD, 0);
        hq[0].push_back(c0); hq[2].push_back(c2);
        expect_read(0, 0); expect_read(2, 0);
        wait_cmds("t1_count", 2, 40);
        chk("t1_first", ilog[0], {4'd0, 8'd0, c0});
        chk("t1_second", ilog[1], {4'd2, 8'd0, c2});
        mlast = 2;
        ret(16);
        cmp_ret("t1_ret");
        // gapped 16-word write on port 1 with controller backpressure
        clr();
        gap = 1;
        w = rnd_cmd(CMD_WR, 1);
        for (int k = 0; k < 16; k++) begin
            ew.push_back(DW'($urandom));
            wq[1].push_back(ew[k]);
        end
        hq[1].push_back(w);
        tick(6);
        bus.c_notfull = 0;
        tick(3);
        bus.c_notfull = 1;
        wait_cmds("t2_count", 1, 300);
        chk("t2_ndin", 64'(dlog.size()), 16);
        for (int k = 0; k < 16 && k < dlog.size(); k++) chk("t2_word", dlog[k], {4'd1, ew[k], AW'(0)});
        chk("t2_cmd", ilog[0], {4'd1, 8'd16, w});
        chk("t2_stall", 64'(stall_put), 0);
        gap = 0;
        mlast = 1;
        // every port continuously valid: grants rotate from the last served port
        clr();
        for (int p = 0; p < NP; p++) for (int j = 0; j < 2; j++) begin
            pl[p][j] = rnd_cmd(other_cmd(), 2'($urandom));
            hq[p].push_back(pl[p][j]);
        end
        wait_cmds("t3_count", 8, 100);
        for (int k = 0; k < 8; k++) chk("t3_grant", ilog[k], {4'((mlast + 1 + k) % NP), 8'd0, pl[(mlast + 1 + k) % NP][k / NP]});
        mlast = (mlast + 8) % NP;
        // reads of different sizes route their returns in issue order
        clr();
        r3 = rnd_cmd(CMD_RD, 0);
        hq[3].push_back(r3);
        wait_cmds("t4_count1", 1, 40);
        r1 = rnd_cmd(CMD_RD, 1);
        hq[1].push_back(r1);
        wait_cmds("t4_count2", 2, 40);
        chk("t4_rd3", ilog[0], {4'd3, 8'd0, r3});
        chk("t4_rd1", ilog[1], {4'd1, 8'd0, r1});
        expect_read(3, 0); expect_read(1, 1);
        ret(24);
        cmp_ret("t4_ret");
        // full tag queue blocks a read but lets a write through
        clr();
        for (int k = 0; k < 16; k++) begin
            hq[2].push_back(rnd_cmd(CMD_RD, 0));
            expect_read(2, 0);
        end
        wait_cmds("t5_fill", 16, 200);
        pr0 = rnd_cmd(CMD_RD, 0); pw1 = rnd_cmd(CMD_WR, 0);
        for (int k = 0; k < 8; k++) wq[1].push_back(DW'($urandom));
        hq[0].push_back(pr0); hq[1].push_back(pw1);
        wait_cmds("t5_write", 17, 100);
        chk("t5_wcmd", ilog[16], {4'd1, 8'd8, pw1});
        tick(20);
        chk("t5_rd_blocked", 64'(ilog.size()), 17);
        expect_read(0, 0);
        ret(136);
        wait_cmds("t5_rd_late", 18, 10);
        chk("t5_rcmd", ilog[17], {4'd0, 8'd8, pr0});
        cmp_ret("t5_ret");
        // orphan return, then reset in the middle of a write burst
        clr();
        chk("t6_err_before", bus.err_orphan, 0);
        bus.c_validout = 1;
        bus.c_dout = DW'($urandom);
        tick(1);
        bus.c_validout = 0;
        tick(1);
        chk("t6_orphan_rvalid", 64'(rlog.size()), 0);
        chk("t6_err_set", bus.err_orphan, 1);
        for (int k = 0; k < 3; k++) wq[0].push_back(DW'($urandom));
        hq[0].push_back(rnd_cmd(CMD_WR, 0));
        tick(12);
        chk("t6_partial_din", 64'(dlog.size()), 3);
        chk("t6_no_cmd", 64'(ilog.size()), 0);
        resetbar = 0;
        for (int i = 0; i < NP; i++) begin
            hq[i].delete();
            wq[i].delete();
        end
        #1;
        chk("t6_rst_err", bus.err_orphan, 0);
        chk("t6_rst_outs", {bus.c_cmd_put, bus.c_din_put, bus.p_wready, bus.p_cmd_ready, bus.p_rvalid}, 0);
        tick(2);
        resetbar = 1;
        tick(4);
        chk("t6_idle_after", 64'(ilog.size() + dlog.size()), 3);
        clr();
        r1 = rnd_cmd(CMD_RD, 0); c0 = rnd_cmd(CMD_RD, 0);
        hq[1].push_back(r1); hq[0].push_back(c0);
        expect_read(0, 0); expect_read(1, 0);
        wait_cmds("t6_count", 2, 40);
        chk("t6_first", ilog[0], {4'd0, 8'd0, c0});
        chk("t6_second", ilog[1], {4'd1, 8'd0, r1});
        ret(16);
        cmp_ret("t6_ret");
        chk("t6_err_clear", bus.err_orphan, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
